// File: rtl/i_fetch.sv
// MIPS IF stage: PC register, word-addressed instruction memory with a write port, and the IF/ID register.
// Build option: define IF_FLUSH_EN to squash IF/ID on a taken branch; otherwise the wrong-path word is kept.
module i_fetch #(
  parameter int MEM_DEPTH = 128,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_PCSrc,
  input  logic [31:0]       EX_MEM_NPC,
  input  logic              stall,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic [31:0]       IF_ID_Instr,
  output logic [31:0]       IF_ID_NPC,
  output logic [31:0]       pc_out
);

  logic [31:0] imem [MEM_DEPTH];
  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;
  logic [31:0] fetch_word_p0;
  logic [31:0] branch_tgt;
  logic        unused_npc_lsbs;

  // Branch targets are forced to word alignment; the dropped bits carry no meaning.
  assign branch_tgt      = {EX_MEM_NPC[31:2], 2'b00};
  assign unused_npc_lsbs = ^EX_MEM_NPC[1:0];

  assign pc_plus4_p0   = pc_p0 + 32'd4;
  assign fetch_word_p0 = imem[pc_p0[ADDR_W+1:2]];
  assign pc_out        = pc_p0;

  // Memory is never reset; a write on the same edge as a fetch leaves that fetch with the old word.
  always_ff @(posedge clk) begin
    if (imem_we)
      imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc_p0 <= 32'd0;
    else if (EX_MEM_PCSrc)
      pc_p0 <= branch_tgt;
    else if (!stall)
      pc_p0 <= pc_plus4_p0;
  end

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      IF_ID_Instr <= 32'd0;
      IF_ID_NPC   <= 32'd0;
    end
`ifdef IF_FLUSH_EN
    else if (EX_MEM_PCSrc) begin
      IF_ID_Instr <= 32'd0;
      IF_ID_NPC   <= 32'd0;
    end
`endif
    else if (!stall) begin
      IF_ID_Instr <= fetch_word_p0;
      IF_ID_NPC   <= pc_plus4_p0;
    end
  end

endmodule

// File: tb/tb_i_fetch.sv
// Table-driven bench for i_fetch: each record drives one clock edge and checks PC and IF/ID after it.
module tb_i_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_MEM_PCSrc;
  logic [31:0] EX_MEM_NPC;
  logic        stall;
  logic        imem_we;
  logic [6:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_NPC;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  i_fetch #(.MEM_DEPTH(128), .ADDR_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .EX_MEM_PCSrc (EX_MEM_PCSrc),
    .EX_MEM_NPC   (EX_MEM_NPC),
    .stall        (stall),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_NPC    (IF_ID_NPC),
    .pc_out       (pc_out)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        pcsrc;
    logic [31:0] npc_in;
    logic        stall;
    logic        we;
    logic [6:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_npc;
  } vec_t;

  localparam logic [31:0] W0 = 32'h002300AA, W1 = 32'h10654321, W2 = 32'h00100022,
                          W3 = 32'h8C123456, W4 = 32'h44440004, W5 = 32'h55550005,
                          W6 = 32'h66660006, W7 = 32'h77770007, W127 = 32'h7F7F007F,
                          WNEW2 = 32'hAD654321, WNEW5 = 32'h5A5A5A5A;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_fail    = 0;

  task automatic add(input string name, input logic r, input logic br, input logic [31:0] tgt,
                     input logic st, input logic we, input logic [6:0] wa, input logic [31:0] wd,
                     input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] en);
    vec_t v;
    v.name = name; v.rst = r; v.pcsrc = br; v.npc_in = tgt; v.stall = st;
    v.we = we; v.waddr = wa; v.wdata = wd;
    v.exp_pc = epc; v.exp_instr = ei; v.exp_npc = en;
`ifdef IF_FLUSH_EN
    if (br) begin
      v.exp_instr = 32'd0;
      v.exp_npc   = 32'd0;
    end
`endif
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic br, input logic [31:0] tgt, input logic st,
                       input logic we, input logic [6:0] wa, input logic [31:0] wd);
    @(negedge clk);
    rst = r; EX_MEM_PCSrc = br; EX_MEM_NPC = tgt; stall = st;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] epc, input logic [31:0] ei,
                       input logic [31:0] en);
    n_applied++;
    if (pc_out !== epc || IF_ID_Instr !== ei || IF_ID_NPC !== en) begin
      n_fail++;
      $display("FAIL %s: got pc=%h instr=%h npc=%h, required pc=%h instr=%h npc=%h",
               name, pc_out, IF_ID_Instr, IF_ID_NPC, epc, ei, en);
    end
  endtask

  initial begin
    logic [31:0] preload [9];
    logic [6:0]  pre_addr [9];
    preload  = '{W0, W1, W2, W3, W4, W5, W6, W7, W127};
    pre_addr = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd127};

    //   name          rst br tgt            st we wa    wd      pc            instr  npc
    add("seq0",        0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h4,        W0,    32'h4);
    add("seq1",        0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h8,        W1,    32'h8);
    add("stall1",      0, 0, 32'h0,          1, 0, 7'd0, 32'h0,  32'h8,        W1,    32'h8);
    add("stall2",      0, 0, 32'h0,          1, 0, 7'd0, 32'h0,  32'h8,        W1,    32'h8);
    add("resume",      0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'hC,        W2,    32'hC);
    add("seq3",        0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h10,       W3,    32'h10);
    add("br_misalign", 0, 1, 32'h1E,         0, 0, 7'd0, 32'h0,  32'h1C,       W4,    32'h14);
    add("br_target",   0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h20,       W7,    32'h20);
    add("br_stall",    0, 1, 32'h200,        1, 0, 7'd0, 32'h0,  32'h200,      W7,    32'h20);
    add("alias0",      0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h204,      W0,    32'h204);
    add("alias1",      0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h208,      W1,    32'h208);
    add("rdw_old",     0, 0, 32'h0,          0, 1, 7'd2, WNEW2,  32'h20C,      W2,    32'h20C);
    add("br_back",     0, 1, 32'h8,          0, 0, 7'd0, 32'h0,  32'h8,        W3,    32'h210);
    add("rdw_new",     0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'hC,        WNEW2, 32'hC);
    add("to_0x10",     0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h10,       W3,    32'h10);
    add("mid_reset",   1, 0, 32'h40,         1, 1, 7'd5, WNEW5,  32'h0,        32'h0, 32'h0);
    add("post_rst",    0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h4,        W0,    32'h4);
    add("br_0x14",     0, 1, 32'h14,         0, 0, 7'd0, 32'h0,  32'h14,       W1,    32'h8);
    add("rst_write",   0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h18,       WNEW5, 32'h18);
    add("br_top",      0, 1, 32'hFFFFFFFF,   0, 0, 7'd0, 32'h0,  32'hFFFFFFFC, W6,    32'h1C);
    add("pc_wrap",     0, 0, 32'h0,          0, 0, 7'd0, 32'h0,  32'h0,        W127,  32'h0);
    // Reset has priority over a simultaneous branch and stall.
    vecs[15].pcsrc = 1'b1;

    rst = 1'b1; EX_MEM_PCSrc = 1'b0; EX_MEM_NPC = '0; stall = 1'b0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

    for (int i = 0; i < 9; i++)
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, pre_addr[i], preload[i]);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    check("reset_state", 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].pcsrc, vecs[i].npc_in, vecs[i].stall,
            vecs[i].we, vecs[i].waddr, vecs[i].wdata);
      check(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_npc);
    end

    // Long stall run: nothing moves for any number of stalled edges.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 7'd0, 32'h0);
      check("stall_run", 32'h4, W0, 32'h4);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    check("stall_release", 32'h8, W1, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/i_fetch.md
# i_fetch

MIPS IF (fetch) stage: owns the program counter, a word-addressed instruction memory and the IF/ID pipeline register. It produces `IF_ID_Instr` and `IF_ID_NPC`, which feed the ID stage, and accepts branch redirects from EX/MEM and stalls from hazard detection. The instruction memory is loaded through a synchronous write port before or during execution.

## Interface
- `MEM_DEPTH`, 128: instruction memory depth in 32-bit words; power of two, minimum 4.
- `ADDR_W`, 7: word-index width, equal to log2(`MEM_DEPTH`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `EX_MEM_PCSrc`  in  1  branch taken; redirect the PC this cycle.
- `EX_MEM_NPC`  in  32  branch target byte address.
- `stall`  in  1  hold the PC and IF/ID (load-use hazard).
- `imem_we`  in  1  instruction memory write enable.
- `imem_waddr`  in  `ADDR_W`  instruction memory word index to write.
- `imem_wdata`  in  32  instruction word to write.
- `IF_ID_Instr`  out  32  latched instruction.
- `IF_ID_NPC`  out  32  latched PC+4 of that instruction.
- `pc_out`  out  32  current PC (debug and trace).

## Operation
- **PC register**
  - Reset value is 0.
  - Next-PC priority: `rst`, then `EX_MEM_PCSrc`, then `stall`, then sequential.
  - `rst`: PC = 0.
  - `EX_MEM_PCSrc`: PC = {`EX_MEM_NPC`[31:2], 2'b00}. The low 2 bits are ignored, so the PC is always word-aligned.
  - `stall` with no branch: PC holds.
  - Otherwise: PC = PC + 4, with 32-bit wrap (0xFFFFFFFC + 4 = 0).
- **Fetch read**
  - Combinational read: `imem[PC[ADDR_W+1:2]]`.
  - Upper PC bits are ignored, so addresses alias modulo `MEM_DEPTH`*4 bytes.
- **Instruction memory write**
  - When `imem_we` = 1, `imem[imem_waddr]` is written on the rising edge.
  - Memory contents are not cleared by `rst`. Contents before the first write are undefined; the bench must load them.
- **IF/ID register**
  - `rst`: `IF_ID_Instr` = 0 (NOP) and `IF_ID_NPC` = 0.
  - `stall` = 1: both fields hold, except where the flush rule below applies.
  - Otherwise: `IF_ID_Instr` = fetched word and `IF_ID_NPC` = PC + 4.
- **Read during write, same word index:** the fetch latched at that edge gets the old contents. The new word is visible from the next cycle.
- **Reset mid-stream:** PC and IF/ID return to 0 on the next edge regardless of `stall`, `EX_MEM_PCSrc` or `imem_we`. Any memory write on that same edge still completes.
- `pc_out` equals the PC register.

## Timing
- One instruction per cycle when not stalled.
- Fetch latency: the word at PC appears on `IF_ID_Instr` one edge after PC holds that value.
- **Branch**
  - `EX_MEM_PCSrc` sampled high at edge N makes PC = target after edge N.
  - The target instruction appears on `IF_ID_Instr` after edge N+1.
- **Stall**
  - Each cycle `stall` is high freezes PC and IF/ID for exactly that edge. There is no internal counter.
  - Release resumes fetching from the held PC.
- **Stall and branch together:** the PC takes the target. IF/ID behaviour is set by the configuration macro.
- First fetched instruction after reset is released: `imem[0]` latches on the first non-reset edge, with `IF_ID_NPC` = 4.

## Configuration
- Macro: `IF_FLUSH_EN`.
- **Defined:**
  - Any edge with `EX_MEM_PCSrc` = 1 loads IF/ID with `IF_ID_Instr` = 0 and `IF_ID_NPC` = 0, squashing the wrong-path instruction.
  - The flush overrides `stall`.
- **Undefined:**
  - No flush. On a branch edge IF/ID follows the normal rule: it holds if `stall` = 1, otherwise it loads the wrong-path fetched word.
  - The pipeline relies on compiler-inserted delay slots.

## Test plan
- **Reset and sequential fetch:** load `imem[0..3]` = 0x002300AA, 0x10654321, 0x00100022, 0x8C123456, then release `rst`. Required: the four words on `IF_ID_Instr` on consecutive cycles, with `IF_ID_NPC` = 4, 8, 12, 16.
- **Stall:** assert `stall` for 2 cycles while `pc_out` = 8. Required: `pc_out` stays 8 and `IF_ID_Instr`/`IF_ID_NPC` hold 0x10654321/8 for 2 cycles. Then 0x00100022/12 follows.
- **Branch:** `EX_MEM_PCSrc` = 1 with `EX_MEM_NPC` = 0x1E (misaligned). Required: `pc_out` = 0x1C, and the next fetch returns `imem[7]` with `IF_ID_NPC` = 0x20.
- **Branch squash:**
  - With `IF_FLUSH_EN` defined: `IF_ID_Instr` = 0 and `IF_ID_NPC` = 0 on the branch edge, even with `stall` = 1.
  - Undefined: the wrong-path word appears instead.
- **Wrap:** with `MEM_DEPTH` = 128, branch to 0x200. Required: `imem[0]` is fetched and `IF_ID_NPC` = 0x204.
- **Write during fetch and mid-run reset:**
  - Write `imem[2]` = 0xAD654321 on the same edge that fetches index 2. Required: the old word is latched.
  - Pulse `rst` while `pc_out` = 0x10. Required: `pc_out`, `IF_ID_Instr` and `IF_ID_NPC` = 0 after that edge.
